// File: rtl/bitstream_bank_loader.sv
// bitstream_bank_loader
//    Configuration front-end for the fabric memory bank. Collects the
//    bitstream one DATA_W-bit beat at a time into a full bit-line row, then
//    strobes that row's one-hot word line, row after row, and finally raises
//    cfg_done so the fabric's global_resetn can be released.
//
// Ports:
//    clk, reset          configuration clock, asynchronous active-high reset
//    start               single-cycle request to begin a full configuration
//    s_valid/s_data      input stream word
//    s_ready             loader accepts a word this cycle
//    bl_config_region_0  bit-line drive, beat k bit j -> bl[k*DATA_W + j]
//    wl_config_region_0  one-hot word-line drive (high only in PULSE)
//    row_idx             row currently being filled or written
//    busy                configuration in progress
//    cfg_done            all rows written; held until next start or reset
module bitstream_bank_loader #(
   parameter int BL_W      = 514,
   parameter int WL_W      = 407,
   parameter int DATA_W    = 32,
   parameter int PULSE_CYC = 2,
   parameter int GAP_CYC   = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     s_valid,
   input  logic [DATA_W-1:0]        s_data,
   output logic                     s_ready,
   output logic [0:BL_W-1]          bl_config_region_0,
   output logic [0:WL_W-1]          wl_config_region_0,
   output logic [$clog2(WL_W)-1:0]  row_idx,
   output logic                     busy,
   output logic                     cfg_done
);

   localparam int WPR  = (BL_W + DATA_W - 1) / DATA_W;
   localparam int BCW  = (WPR > 1) ? $clog2(WPR) : 1;
   localparam int TMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
   localparam int TCW  = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int RW   = $clog2(WL_W);

   typedef enum logic [2:0] {IDLE, FILL, PULSE, GAP, DONE} state_t;

   state_t          state, state_nxt;
   logic [BCW-1:0]  beat_cnt;
   logic [TCW-1:0]  tmr;
   logic            beat_fire, last_beat, pulse_end, gap_end, last_row;
   logic [0:BL_W-1] wr_en, wr_bit;

   assign beat_fire = (state == FILL) && s_valid;
   assign last_beat = (beat_cnt == BCW'(WPR - 1));
   assign pulse_end = (tmr == TCW'(PULSE_CYC - 1));
   assign gap_end   = (tmr == TCW'(GAP_CYC - 1));
   assign last_row  = (row_idx == RW'(WL_W - 1));

   // Static bit map: each bl bit belongs to exactly one beat/bit position.
   // Positions past BL_W in the final beat simply have no bl bit to land in.
   for (genvar g = 0; g < BL_W; g++) begin : g_map
      assign wr_en[g]  = beat_fire && (beat_cnt == BCW'(g / DATA_W));
      assign wr_bit[g] = s_data[g % DATA_W];
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = FILL;
         FILL:    if (beat_fire && last_beat) state_nxt = PULSE;
         PULSE:   if (pulse_end) state_nxt = GAP;
         GAP:     if (gap_end) state_nxt = last_row ? DONE : FILL;
         DONE:    if (start) state_nxt = FILL;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs. wl is decoded straight from the state register so it falls
   // together with the asynchronous reset, never waiting for a clock.
   always_comb begin
      s_ready            = (state == FILL);
      busy               = (state == FILL) || (state == PULSE) || (state == GAP);
      cfg_done           = (state == DONE);
      wl_config_region_0 = '0;
      if (state == PULSE) wl_config_region_0[row_idx] = 1'b1;
   end

   // Datapath: beat/row counters, pulse/gap timer, bit-line row
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         beat_cnt           <= '0;
         tmr                <= '0;
         row_idx            <= '0;
         bl_config_region_0 <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  beat_cnt           <= '0;
                  tmr                <= '0;
                  row_idx            <= '0;
                  bl_config_region_0 <= '0;
               end
            end
            FILL: begin
               tmr <= '0;
               if (beat_fire) begin
                  bl_config_region_0 <= (bl_config_region_0 & ~wr_en) | (wr_bit & wr_en);
                  beat_cnt           <= last_beat ? '0 : beat_cnt + BCW'(1);
               end
            end
            PULSE: tmr <= pulse_end ? '0 : tmr + TCW'(1);
            GAP: begin
               if (gap_end) begin
                  tmr      <= '0;
                  beat_cnt <= '0;
                  // Last row: release the bit lines; row_idx parks on WL_W-1.
                  if (last_row) bl_config_region_0 <= '0;
                  else          row_idx <= row_idx + RW'(1);
               end else begin
                  tmr <= tmr + TCW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bitstream_bank_loader.sv
// Directed bench: one loader at default sizes (single-row timing, full-width
// row) and one at BL_W=10/WL_W=3/DATA_W=4 (bit mapping, stalls, full load,
// restart, reset mid-pulse).
module tb_bitstream_bank_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   // default-parameter instance
   logic         b_start, b_valid, b_ready, b_busy, b_done;
   logic [31:0]  b_data;
   logic [0:513] b_bl;
   logic [0:406] b_wl;
   logic [8:0]   b_row;

   // small-parameter instance
   logic         s_start, s_valid, s_ready, s_busy, s_done;
   logic [3:0]   s_data;
   logic [0:9]   s_bl;
   logic [0:2]   s_wl;
   logic [1:0]   s_row;

   int tests = 0;
   int fails = 0;

   logic [0:406] b_wl_exp;

   bitstream_bank_loader u_big (
      .clk(clk), .reset(reset), .start(b_start), .s_valid(b_valid), .s_data(b_data),
      .s_ready(b_ready), .bl_config_region_0(b_bl), .wl_config_region_0(b_wl),
      .row_idx(b_row), .busy(b_busy), .cfg_done(b_done));

   bitstream_bank_loader #(.BL_W(10), .WL_W(3), .DATA_W(4), .PULSE_CYC(2), .GAP_CYC(1)) u_sml (
      .clk(clk), .reset(reset), .start(s_start), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .bl_config_region_0(s_bl), .wl_config_region_0(s_wl),
      .row_idx(s_row), .busy(s_busy), .cfg_done(s_done));

   task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One small-instance row from FILL through GAP, ending back at the next
   // state's first cycle. Optional stall after the first beat.
   task automatic sml_row(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                          input int stall, input logic [0:9] ebl, input logic [0:2] ewl,
                          input logic [1:0] erow);
      check("s_fill_ready", 1024'(s_ready), 1024'(1'b1));
      check("s_fill_row", 1024'(s_row), 1024'(erow));
      s_valid = 1'b1; s_data = d0; step();
      if (stall > 0) begin
         s_valid = 1'b0; s_data = 4'h9;
         for (int i = 0; i < stall; i++) begin
            step();
            check("s_stall_wl", 1024'(s_wl), 1024'(3'b000));
            check("s_stall_ready", 1024'(s_ready), 1024'(1'b1));
         end
         check("s_stall_bl_hold", 1024'(s_bl[0:3]), 1024'(ebl[0:3]));
         s_valid = 1'b1;
      end
      s_data = d1; step();
      s_data = d2; step();
      // keep offering a word while not ready: it must not be consumed
      s_data = 4'h6;
      check("s_pulse1_wl", 1024'(s_wl), 1024'(ewl));
      check("s_pulse1_bl", 1024'(s_bl), 1024'(ebl));
      check("s_pulse1_ready", 1024'(s_ready), 1024'(1'b0));
      check("s_pulse1_busy", 1024'(s_busy), 1024'(1'b1));
      step();
      check("s_pulse2_wl", 1024'(s_wl), 1024'(ewl));
      step();
      check("s_gap_wl", 1024'(s_wl), 1024'(3'b000));
      check("s_gap_bl", 1024'(s_bl), 1024'(ebl));
      s_valid = 1'b0;
      step();
   endtask

   initial begin
      reset = 1'b1;
      b_start = 1'b0; b_valid = 1'b0; b_data = '0;
      s_start = 1'b0; s_valid = 1'b0; s_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 1024'(b_ready), 1024'(1'b0));
      check("rst_wl", 1024'(b_wl), 1024'(0));
      check("rst_bl", 1024'(b_bl), 1024'(0));
      check("rst_row", 1024'(b_row), 1024'(0));
      check("rst_busy", 1024'(b_busy), 1024'(1'b0));
      check("rst_done", 1024'(b_done), 1024'(1'b0));
      reset = 1'b0;

      // idle with valid held high and no start: nothing happens
      b_valid = 1'b1; b_data = 32'hFFFF_FFFF;
      s_valid = 1'b1; s_data = 4'hF;
      repeat (5) begin
         step();
         check("idle_ready", 1024'(b_ready), 1024'(1'b0));
         check("idle_wl", 1024'(b_wl), 1024'(0));
      end
      check("idle_done", 1024'(b_done), 1024'(1'b0));
      check("idle_bl", 1024'(b_bl), 1024'(0));
      s_valid = 1'b0;

      // default instance: one row of all-ones, 17 beats
      b_start = 1'b1; step(); b_start = 1'b0;
      check("big_fill_ready", 1024'(b_ready), 1024'(1'b1));
      check("big_fill_busy", 1024'(b_busy), 1024'(1'b1));
      repeat (16) step();
      check("big_beat16_ready", 1024'(b_ready), 1024'(1'b1));
      check("big_beat16_wl", 1024'(b_wl), 1024'(0));
      step();
      b_valid = 1'b0;
      b_wl_exp = '0; b_wl_exp[0] = 1'b1;
      check("big_pulse1_wl", 1024'(b_wl), 1024'(b_wl_exp));
      check("big_pulse1_bl", 1024'(b_bl), 1024'({514{1'b1}}));
      check("big_pulse1_ready", 1024'(b_ready), 1024'(1'b0));
      step();
      check("big_pulse2_wl", 1024'(b_wl), 1024'(b_wl_exp));
      step();
      check("big_gap_wl", 1024'(b_wl), 1024'(0));
      check("big_gap_bl", 1024'(b_bl), 1024'({514{1'b1}}));
      step();
      check("big_row1_ready", 1024'(b_ready), 1024'(1'b1));
      check("big_row1_idx", 1024'(b_row), 1024'(1));
      check("big_row1_wl", 1024'(b_wl), 1024'(0));

      // small instance: full 3-row load, stall in row 0
      s_start = 1'b1; step(); s_start = 1'b0;
      sml_row(4'hA, 4'h5, 4'hF, 5, 10'b0101_1010_11, 3'b100, 2'd0);
      sml_row(4'h3, 4'hC, 4'h1, 0, 10'b1100_0011_10, 3'b010, 2'd1);
      sml_row(4'h0, 4'hF, 4'h2, 0, 10'b0000_1111_01, 3'b001, 2'd2);
      check("s_done", 1024'(s_done), 1024'(1'b1));
      check("s_done_busy", 1024'(s_busy), 1024'(1'b0));
      check("s_done_bl", 1024'(s_bl), 1024'(0));
      check("s_done_wl", 1024'(s_wl), 1024'(0));
      check("s_done_row", 1024'(s_row), 1024'(2'd2));
      step();
      check("s_done_sticky", 1024'(s_done), 1024'(1'b1));

      // restart from DONE
      s_start = 1'b1; step(); s_start = 1'b0;
      check("s_restart_done", 1024'(s_done), 1024'(1'b0));
      check("s_restart_bl", 1024'(s_bl), 1024'(0));
      sml_row(4'h1, 4'h2, 4'h3, 0, 10'b1000_0100_11, 3'b100, 2'd0);

      // row 1, then reset during its pulse
      check("s_r1_row", 1024'(s_row), 1024'(2'd1));
      s_valid = 1'b1;
      s_data = 4'h7; step();
      s_data = 4'h8; step();
      s_data = 4'h0; step();
      s_valid = 1'b0;
      check("s_r1_pulse_wl", 1024'(s_wl), 1024'(3'b010));
      check("s_r1_pulse_bl", 1024'(s_bl), 1024'(10'b1110_0001_00));
      #2 reset = 1'b1;
      #1;
      check("s_rst_wl", 1024'(s_wl), 1024'(3'b000));
      check("s_rst_bl", 1024'(s_bl), 1024'(0));
      check("s_rst_row", 1024'(s_row), 1024'(0));
      check("s_rst_busy", 1024'(s_busy), 1024'(1'b0));
      step();
      reset = 1'b0;
      step();
      check("s_post_rst_ready", 1024'(s_ready), 1024'(1'b0));
      check("s_post_rst_busy", 1024'(s_busy), 1024'(1'b0));
      check("s_post_rst_done", 1024'(s_done), 1024'(1'b0));

      // fresh start reloads from row 0
      s_start = 1'b1; step(); s_start = 1'b0;
      sml_row(4'hA, 4'h5, 4'hF, 0, 10'b0101_1010_11, 3'b100, 2'd0);
      check("s_reload_row", 1024'(s_row), 1024'(2'd1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
